// File: rtl/fetch_queue.sv
// fetch_queue: in-order PC/instruction buffer between the fetch and decode stages.
// Optional empty-queue bypass to decode is compiled in with `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_inst,
    output logic                       full_stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] pcMem   [DEPTH];
    logic [WIDTH-1:0] instMem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] countQ;
    logic             empty, push, popStore, bypassHit;

    assign empty      = (countQ == '0);
    assign full_stall = (countQ == FULL_CNT);
    assign count      = countQ;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypassHit = empty & in_valid & ~flush;
`else
    assign bypassHit = 1'b0;
`endif

    // A bypassed pair consumed by decode in the same cycle is never written.
    assign popStore = ~empty & out_ready & ~flush;
    assign push     = in_valid & ~full_stall & ~flush & ~(bypassHit & out_ready);

    always_comb begin
        out_valid = ~empty;
        out_pc    = '0;
        out_inst  = '0;
        if (!empty) begin
            out_pc   = pcMem[rdPtr];
            out_inst = instMem[rdPtr];
        end else if (bypassHit) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]   <= in_pc;
            instMem[wrPtr] <= in_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
        end else if (flush) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PTR_W'(1);
            if (popStore)
                rdPtr <= rdPtr + PTR_W'(1);
            case ({push, popStore})
                2'b10:   countQ <= countQ + CNT_W'(1);
                2'b01:   countQ <= countQ - CNT_W'(1);
                default: countQ <= countQ;
            endcase
        end
    end
endmodule
